// File: rtl/reg_dump_pkg.sv
// Shared constants, state encodings and the frame-byte helper for the register dump engine.
package reg_dump_pkg;

    localparam logic [7:0]  SYNC_BYTE   = 8'hA5;
    localparam int unsigned NUM_REGS    = 8;
    localparam int unsigned FRAME_BYTES = 9;
    localparam int unsigned REG_AW      = $clog2(NUM_REGS);
    localparam int unsigned BYTE_IDX_W  = 4;

    // Top-level sequencing; START/DATA/STOP live inside the byte transmitter.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StDone
    } dump_state_e;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } tx_state_e;

    function automatic logic [7:0] frame_byte(input logic [BYTE_IDX_W-1:0] idx,
                                              input logic [7:0]            rd_data);
        return (idx == '0) ? SYNC_BYTE : rd_data;
    endfunction

endpackage

// File: rtl/reg_dump_tx_if.sv
// Command, register-file read port and UART line of the register dump engine.
interface reg_dump_tx_if;
    import reg_dump_pkg::*;

    logic              start;
    logic [REG_AW-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              tx;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output rd_data,
        input  rd_addr,
        input  tx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  rd_data,
        output rd_addr,
        output tx,
        output busy,
        output done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: baud counter, start/data/stop sequencing and the registered tx line.
module uart_tx_byte
    import reg_dump_pkg::*;
#(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       byte_done_o,
    output logic       tx_o
);

    localparam int unsigned     CntW    = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClksPerBit - 1);

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= TxIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
        end
    end

    assign bit_end = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        tx_d        = tx_q;
        byte_done_o = 1'b0;

        unique case (state_q)
            TxIdle: begin
                cnt_d = '0;
                tx_d  = 1'b1;
                if (load_i) begin
                    shreg_d   = data_i;
                    bit_idx_d = '0;
                    tx_d      = 1'b0;
                    state_d   = TxStart;
                end
            end
            TxStart: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                    state_d   = TxData;
                end
            end
            TxData: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    // tx is registered, so the next bit is presented from the pre-shift value.
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = TxStop;
                    end else begin
                        tx_d = shreg_q[1];
                    end
                end
            end
            TxStop: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                tx_d  = 1'b1;
                if (bit_end) begin
                    byte_done_o = 1'b1;
                    state_d     = TxIdle;
                end
            end
        endcase
    end

    assign ready_o = (state_q == TxIdle);
    assign tx_o    = tx_q;

endmodule

// File: rtl/reg_dump_tx.sv
// Register-file dump engine: walks r0..r7 and sends 0xA5 plus the eight values over 8N1 UART.
module reg_dump_tx
    import reg_dump_pkg::*;
#(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic         clk_i,
    input  logic         rst_i,
    reg_dump_tx_if.slave dump_io
);

    dump_state_e           state_q, state_d;
    logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
    logic [REG_AW-1:0]     rd_addr_q, rd_addr_d;
    logic                  tx_load;
    logic                  tx_ready;
    logic                  tx_byte_done;
    logic                  tx_line;
    logic [7:0]            tx_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        rd_addr_d  = rd_addr_q;
        tx_load    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dump_io.start) begin
                    byte_idx_d = '0;
                    rd_addr_d  = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                // rd_data is sampled here, so writes after this cycle miss this byte.
                tx_load = tx_ready;
                if (tx_ready) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx_byte_done) begin
                    if (byte_idx_q == BYTE_IDX_W'(FRAME_BYTES - 1)) begin
                        state_d = StDone;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        rd_addr_d  = byte_idx_q[REG_AW-1:0];
                        state_d    = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_data = frame_byte(byte_idx_q, dump_io.rd_data);

    uart_tx_byte #(
        .ClksPerBit (ClksPerBit)
    ) u_uart_tx_byte (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (tx_load),
        .data_i      (tx_data),
        .ready_o     (tx_ready),
        .byte_done_o (tx_byte_done),
        .tx_o        (tx_line)
    );

    assign dump_io.rd_addr = rd_addr_q;
    assign dump_io.tx      = tx_line;
    assign dump_io.busy    = (state_q != StIdle);
    assign dump_io.done    = (state_q == StDone);

endmodule
